// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one Rsa256Core between two requesters.
// Latches the winner's operands, pulses core_start, waits (with optional watchdog) and routes the result back.
module rsa_core_arbiter #(
    parameter int W              = 256,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic         avm_clk,
    input  logic         avm_rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_d,
    input  logic [W-1:0] req0_n,
    output logic         req0_done,
    output logic [W-1:0] req0_result,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_d,
    input  logic [W-1:0] req1_n,
    output logic         req1_done,
    output logic [W-1:0] req1_result,

    output logic         core_start,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_d,
    output logic [W-1:0] core_n,
    input  logic [W-1:0] core_result,
    input  logic         core_finished,

    output logic         busy,
    output logic         grant_id,
    output logic         timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      state_q;
    logic        last_grant_q;
    logic        grant_q;
    logic        start_q;
    logic        busy_q;
    logic        tmo_q;
    logic        done0_q;
    logic        done1_q;
    logic [W-1:0] a_q;
    logic [W-1:0] d_q;
    logic [W-1:0] n_q;
    logic [W-1:0] res0_q;
    logic [W-1:0] res1_q;
    logic [31:0] wd_cnt_q;

    logic        sel_vld;
    logic        grant_d;
    logic        accept;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        sel_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_d = ~last_grant_q;
        end else begin
            grant_d = req1_valid;
        end
    end

    assign accept     = (state_q == IDLE) && sel_vld;
    assign req0_ready = accept && !grant_d;
    assign req1_ready = accept &&  grant_d;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            tmo_q        <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            a_q          <= '0;
            d_q          <= '0;
            n_q          <= '0;
            res0_q       <= '0;
            res1_q       <= '0;
            wd_cnt_q     <= '0;
        end else begin
            start_q <= 1'b0;
            tmo_q   <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= grant_d ? req1_a : req0_a;
                        d_q          <= grant_d ? req1_d : req0_d;
                        n_q          <= grant_d ? req1_n : req0_n;
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        start_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt_q <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (core_finished) begin
                        if (grant_q) begin
                            res1_q  <= core_result;
                            done1_q <= 1'b1;
                        end else begin
                            res0_q  <= core_result;
                            done0_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end else if (WD_EN && (wd_cnt_q == WD_LIMIT)) begin
                        // Abort: result registers untouched, no done pulse.
                        tmo_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (wd_cnt_q != 32'hFFFF_FFFF) begin
                        wd_cnt_q <= wd_cnt_q + 32'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core_start  = start_q;
    assign core_a      = a_q;
    assign core_d      = d_q;
    assign core_n      = n_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign timeout_err = tmo_q;
    assign req0_done   = done0_q;
    assign req1_done   = done1_q;
    assign req0_result = res0_q;
    assign req1_result = res1_q;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Directed bench for rsa_core_arbiter with a behavioural modexp core of programmable latency.
module tb_rsa_core_arbiter;

    localparam int W   = 64;
    localparam int TMO = 16;

    logic         avm_clk = 1'b0;
    logic         avm_rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready, req0_done, req1_done;
    logic [W-1:0] req0_a = '0, req0_d = '0, req0_n = '0;
    logic [W-1:0] req1_a = '0, req1_d = '0, req1_n = '0;
    logic [W-1:0] req0_result, req1_result;
    logic         core_start;
    logic [W-1:0] core_a, core_d, core_n;
    logic [W-1:0] core_result;
    logic         core_finished;
    logic         busy, grant_id, timeout_err;

    logic model_fin;
    logic inj_fin = 1'b0;
    int   core_lat = 5;
    bit   core_en  = 1'b1;
    int   cd;
    bit   mbusy;

    int checks = 0;
    int errors = 0;

    assign core_finished = model_fin | inj_fin;

    always #5 avm_clk = ~avm_clk;

    rsa_core_arbiter #(.W(W), .TIMEOUT_CYCLES(TMO)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_d(req0_d), .req0_n(req0_n),
        .req0_done(req0_done), .req0_result(req0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_d(req1_d), .req1_n(req1_n),
        .req1_done(req1_done), .req1_result(req1_result),
        .core_start(core_start), .core_a(core_a), .core_d(core_d), .core_n(core_n),
        .core_result(core_result), .core_finished(core_finished),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] d, input logic [W-1:0] n);
        logic [63:0] r, b, e;
        r = 64'd1 % n;
        b = a % n;
        e = d;
        while (e != 64'd0) begin
            if (e[0]) r = (r * b) % n;
            b = (b * b) % n;
            e = e >> 1;
        end
        return r;
    endfunction

    // Core model: finished rises core_lat cycles after the start cycle.
    always @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            model_fin   <= 1'b0;
            mbusy       <= 1'b0;
            cd          <= 0;
            core_result <= '0;
        end else begin
            model_fin <= 1'b0;
            if (core_start) begin
                core_result <= modexp(core_a, core_d, core_n);
                if (core_en && core_lat <= 1) begin
                    model_fin <= 1'b1;
                    mbusy     <= 1'b0;
                end else begin
                    cd    <= core_lat - 1;
                    mbusy <= core_en;
                end
            end else if (mbusy) begin
                if (cd == 1) begin
                    model_fin <= 1'b1;
                    mbusy     <= 1'b0;
                end
                cd <= cd - 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge avm_clk);
        #1;
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        inj_fin    = 1'b0;
        @(posedge avm_clk);
        #1 avm_rst = 1'b1;
        @(posedge avm_clk);
        #1 avm_rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant_id); end
        checks++; if ({core_start, timeout_err, req0_done, req1_done} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {core_start, timeout_err, req0_done, req1_done}); end
        checks++; if ((core_a | core_d | core_n) !== '0) begin errors++; $display("FAIL reset_operands: got %0h/%0h/%0h want 0", core_a, core_d, core_n); end
        checks++; if ((req0_result | req1_result) !== '0) begin errors++; $display("FAIL reset_results: got %0d/%0d want 0", req0_result, req1_result); end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL reset_first_tie: got %b want 01", {req1_ready, req0_ready}); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_idle_ready: got %b want 00", {req1_ready, req0_ready}); end
    endtask

    task automatic test_single();
        int extra = 0, dones = 0, done_at = -1, r1d = 0, busy_fall = -1;
        core_en  = 1'b1;
        core_lat = 5;
        req0_a = 64'd2; req0_d = 64'd10; req0_n = 64'd1000003;
        req0_valid = 1'b1;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", {req1_ready, req0_ready}); end
        step();
        req0_valid = 1'b0;
        checks++; if ({core_start, busy, grant_id} !== 3'b110) begin errors++; $display("FAIL single_start: got start/busy/grant %b want 110", {core_start, busy, grant_id}); end
        checks++; if (core_n !== 64'd1000003 || core_a !== 64'd2 || core_d !== 64'd10) begin errors++; $display("FAIL single_latch: got %0d/%0d/%0d want 2/10/1000003", core_a, core_d, core_n); end
        for (int k = 1; k <= 20; k++) begin
            step();
            if (core_start) extra++;
            if (req0_done) begin dones++; if (done_at < 0) done_at = k; end
            if (req1_done) r1d++;
            if (!busy && busy_fall < 0) busy_fall = k;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL single_extra_start: got %0d want 0", extra); end
        checks++; if (dones !== 1 || done_at !== 6) begin errors++; $display("FAIL single_done: got %0d pulses at +%0d want 1 at +6", dones, done_at); end
        checks++; if (busy_fall !== 7) begin errors++; $display("FAIL single_busy_fall: got +%0d want +7", busy_fall); end
        checks++; if (req0_result !== 64'd1024) begin errors++; $display("FAIL single_result: got %0d want 1024", req0_result); end
        checks++; if (req1_result !== '0 || r1d !== 0) begin errors++; $display("FAIL single_req1_untouched: got %0d/%0d want 0/0", req1_result, r1d); end
    endtask

    task automatic test_watchdog();
        int tmos = 0, tmo_at = -1, dones = 0, busy_fall = -1;
        core_en = 1'b0;
        req0_a = 64'd3; req0_d = 64'd4; req0_n = 64'd100;
        req0_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL wd_ready: got %b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (timeout_err) begin tmos++; if (tmo_at < 0) tmo_at = k; end
            if (req0_done || req1_done) dones++;
            if (!busy && busy_fall < 0) busy_fall = k;
        end
        checks++; if (tmos !== 1 || tmo_at !== 17) begin errors++; $display("FAIL wd_timeout: got %0d pulses at +%0d want 1 at +17", tmos, tmo_at); end
        checks++; if (busy_fall !== 17) begin errors++; $display("FAIL wd_busy: got +%0d want +17", busy_fall); end
        checks++; if (dones !== 0) begin errors++; $display("FAIL wd_no_done: got %0d want 0", dones); end
        inj_fin = 1'b1;
        step();
        step();
        inj_fin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (req0_done || req1_done) dones++;
            step();
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL wd_late_finish_done: got %0d want 0", dones); end
        checks++; if (req0_result !== 64'd1024) begin errors++; $display("FAIL wd_result_held: got %0d want 1024", req0_result); end
        core_en = 1'b1;
    endtask

    task automatic test_tie();
        logic [W-1:0] r0_exp = '0, r1_exp = '0;
        logic [W-1:0] job_res [4] = '{64'd81, 64'd6, 64'd32, 64'd9};
        int w;
        logic exp_id;
        apply_reset();
        core_lat = 3;
        req0_a = 64'd3; req0_d = 64'd4; req0_n = 64'd100;
        req1_a = 64'd5; req1_d = 64'd3; req1_n = 64'd7;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            exp_id = logic'(j % 2);
            w = 0;
            while (!(req0_ready || req1_ready) && w < 20) begin step(); w++; end
            checks++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_ready_job%0d: got %b want %b", j, {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01); end
            step();
            checks++; if (grant_id !== exp_id) begin errors++; $display("FAIL tie_grant_job%0d: got %b want %b", j, grant_id, exp_id); end
            if (j == 0) begin req0_a = 64'd2; req0_d = 64'd5; req0_n = 64'd1000; end
            if (j == 1) begin req1_a = 64'd7; req1_d = 64'd2; req1_n = 64'd10; end
            if (j == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            w = 0;
            while (!(req0_done || req1_done) && w < 20) begin step(); w++; end
            if (exp_id) r1_exp = job_res[j]; else r0_exp = job_res[j];
            checks++; if ({req1_done, req0_done} !== (exp_id ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_done_port_job%0d: got %b want %b", j, {req1_done, req0_done}, exp_id ? 2'b10 : 2'b01); end
            checks++; if (req0_result !== r0_exp || req1_result !== r1_exp) begin errors++; $display("FAIL tie_results_job%0d: got %0d/%0d want %0d/%0d", j, req0_result, req1_result, r0_exp, r1_exp); end
        end
    endtask

    task automatic test_back_to_back();
        int w = 0, starts = 0;
        apply_reset();
        core_lat = 3;
        req1_a = 64'd5; req1_d = 64'd3; req1_n = 64'd7;
        req1_valid = 1'b1;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL b2b_ready: got %b want 10", {req1_ready, req0_ready}); end
        step();
        req1_a = 64'd7; req1_d = 64'd2; req1_n = 64'd10;
        while (!req1_done && w < 20) begin step(); w++; if (core_start) starts++; end
        checks++; if (req1_result !== 64'd6 || req1_ready !== 1'b0) begin errors++; $display("FAIL b2b_first_done: got result %0d ready %b want 6 0", req1_result, req1_ready); end
        step();
        checks++; if ({req1_ready, busy, core_start} !== 3'b100) begin errors++; $display("FAIL b2b_done_plus1: got ready/busy/start %b want 100", {req1_ready, busy, core_start}); end
        step();
        req1_valid = 1'b0;
        checks++; if (core_start !== 1'b1 || core_n !== 64'd10) begin errors++; $display("FAIL b2b_second_start: got start %b n %0d want 1 10", core_start, core_n); end
        w = 0;
        while (!req1_done && w < 20) begin step(); w++; if (core_start) starts++; end
        checks++; if (starts !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d extra starts want 0", starts); end
        checks++; if (req1_result !== 64'd9 || req0_result !== '0) begin errors++; $display("FAIL b2b_second_result: got %0d/%0d want 9/0", req1_result, req0_result); end
    endtask

    task automatic test_spurious();
        int dones = 0, done_at = -1;
        apply_reset();
        core_lat = 4;
        req1_a = 64'd5; req1_d = 64'd3; req1_n = 64'd7;
        inj_fin = 1'b1;
        step();
        checks++; if (req1_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL spur_idle: got done %b busy %b want 0 0", req1_done, busy); end
        req1_valid = 1'b1;
        #1;
        step();
        req1_valid = 1'b0;
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL spur_start: got %b want 1", core_start); end
        step();
        inj_fin = 1'b0;
        if (req1_done) begin dones++; done_at = 1; end
        for (int k = 2; k <= 12; k++) begin
            step();
            if (req1_done) begin dones++; if (done_at < 0) done_at = k; end
        end
        checks++; if (dones !== 1 || done_at !== 5) begin errors++; $display("FAIL spur_done: got %0d pulses at +%0d want 1 at +5", dones, done_at); end
        checks++; if (req1_result !== 64'd6) begin errors++; $display("FAIL spur_result: got %0d want 6", req1_result); end
    endtask

    task automatic test_reset_mid();
        int dones = 0, starts = 0;
        core_lat = 10;
        req0_a = 64'd2; req0_d = 64'd10; req0_n = 64'd1000003;
        req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        step(); step(); step();
        avm_rst = 1'b1;
        #1;
        checks++; if ({busy, grant_id, core_start, req0_done, req1_done, timeout_err} !== 6'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b want 000000", {busy, grant_id, core_start, req0_done, req1_done, timeout_err}); end
        checks++; if ((core_a | core_d | core_n | req0_result | req1_result) !== '0) begin errors++; $display("FAIL rstmid_data: got a %0d r1 %0d want 0 0", core_a, req1_result); end
        step();
        avm_rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_tie: got %b want 01", {req1_ready, req0_ready}); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (req0_done || req1_done) dones++;
            if (core_start) starts++;
        end
        checks++; if (dones !== 0 || starts !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d dones %0d starts want 0 0", dones, starts); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_watchdog();
        test_tie();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_core_arbiter.md
# rsa_core_arbiter

Shares one `Rsa256Core` instance between two independent requesters, such as the UART-driven wrapper and a self-test/key-check engine. Round-robin arbitration grants one requester at a time. The block latches that requester's operands, issues a single-cycle start to the core, waits for completion with a watchdog, and returns the result to the granted requester. It sits between the requester FSMs and the core, in the `avm_clk` domain.

## Interface
Parameters:
- `W`, 256: operand/result width.
- `TIMEOUT_CYCLES`, 0: watchdog limit in WAIT cycles; 0 disables the watchdog.

Ports:
- `avm_clk`  in  1  clock.
- `avm_rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  requester 0 has a job.
- `req0_ready`  out  1  requester 0 job accepted this cycle when valid&&ready.
- `req0_a`, `req0_d`, `req0_n`  in  W each  base, exponent, modulus.
- `req0_done`  out  1  one-cycle pulse: `req0_result` is valid.
- `req0_result`  out  W  last result for requester 0, held.
- `req1_*`  same set as `req0_*`, for requester 1.
- `core_start`  out  1  one-cycle start to the core.
- `core_a`, `core_d`, `core_n`  out  W each  latched operands, stable IDLE→next accept.
- `core_result`  in  W  core `o_a_pow_d`.
- `core_finished`  in  1  core `o_finished`.
- `busy`  out  1  high in any state but IDLE.
- `grant_id`  out  1  owner of the current or last job.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE selection:
  - Only one `valid`: select it.
  - Both valid: select the requester ≠ `last_grant`.
  - Neither: no selection.
- `reqN_ready` = (state==IDLE) && selected==N. This is combinational from valid and `last_grant`; ready never asserts for both requesters at once.
- Transfer on valid&&ready:
  - latch `a`/`d`/`n` into the `core_*` registers;
  - set `grant_id` and `last_grant` to N;
  - go to ISSUE.
- Dropping valid before ready is legal; no transfer occurs.
- ISSUE: `core_start`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - `core_finished`=1: capture `core_result` into `reqN_result` (N=`grant_id`); go to DONE.
  - Otherwise, if `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`-1: pulse `timeout_err`, leave the result unchanged, no done pulse, go to IDLE.
  - Otherwise, increment the counter (32-bit, saturating).
- DONE: `reqN_done`=1 for one cycle; go to IDLE.
- `core_finished` is sampled only in WAIT; it is ignored in IDLE, ISSUE and DONE, including a late finish after a timeout.
- The other requester's result register is never modified.
- Operand registers are not cleared after a job; `core_*` keeps the last job's values.

## Timing
- Reset values:
  - state IDLE, `last_grant`=1 (so requester 0 wins the first tie), `grant_id`=0;
  - `core_start`, `reqN_done`, `timeout_err`, `busy` = 0;
  - `core_a`/`core_d`/`core_n` and `reqN_result` = 0.
- Accept edge T: `core_start` is high during T+1 and `busy` is high from T+1.
- `core_finished` high in cycle F≥T+2: `reqN_done` and the new `reqN_result` are visible in F+1.
- IDLE again in F+2, so the earliest next accept edge is F+2.
- `busy` falls at the start of F+2.
- Timeout: `timeout_err` is high in the cycle after the counter hits its limit; IDLE follows immediately.
- Reset mid-operation aborts the job with no done pulse. The core shares `avm_rst` and is reset too.
- Requester held valid during DONE is not accepted until IDLE; there is no bypass.

## Test plan
- Single job, req0 only: a=2, d=10, n=1000003 against a core model that finishes 5 cycles after start. Required: `core_start` exactly one cycle after accept, `req0_done` one pulse, `req0_result`=1024, req1 outputs unchanged.
- Tie fairness: both valid every cycle with distinct operands, 4 jobs. Required: grants 0,1,0,1; each done pulse only on the owning port; `req1_result` never overwritten by a req0 job.
- Back-to-back req1 jobs with req0 idle, core latency 3. Required: second accept exactly 2 cycles after the first done; no overlapping starts.
- Watchdog: `TIMEOUT_CYCLES`=16, core never finishes. Required: `timeout_err` pulses once, no `req0_done`, `busy` returns to 0. A `core_finished` injected afterwards must cause no done pulse and no result change.
- Spurious finish: `core_finished` forced high in the IDLE and ISSUE cycles. Required: ignored; the result is captured only on the WAIT-state finish.
- Reset mid-WAIT: assert `avm_rst` 3 cycles after start. Required: all outputs return to reset values immediately; next tie goes to req0.
